// File: rtl/regfile_sb.sv
// Register file with an integrated scoreboard: two combinational read ports, one write port, per-register pending bits.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW-1:0] rs1_i,
  input  logic [AW-1:0] rs2_i,
  output logic [DW-1:0] datos1_o,
  output logic [DW-1:0] datos2_o,
  input  logic [AW-1:0] rd_i,
  input  logic [DW-1:0] datord_i,
  input  logic          we_i,
  input  logic          iss_i,
  input  logic [AW-1:0] iss_rd_i,
  output logic          pend1_o,
  output logic          pend2_o,
  output logic [AW:0]   pend_cnt_o
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_pend;
  logic [AW:0]      r_cnt;
  logic [DEPTH-1:0] w_pend_nxt;
  logic             w_zero_en;
  logic             w_wr_en;
  logic             w_iss_en;
  logic [DW-1:0]    w_dat1;
  logic [DW-1:0]    w_dat2;
  logic             w_pnd1;
  logic             w_pnd2;

  function automatic logic [AW:0] popcnt(input logic [DEPTH-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  assign w_zero_en = (ZERO_REG != 0);
  assign w_wr_en   = we_i  & ~(w_zero_en & (rd_i == '0));
  assign w_iss_en  = iss_i & ~(w_zero_en & (iss_rd_i == '0));

  // Next pending vector: the set is applied last so a newer producer wins over a retiring one.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_en) begin
      w_pend_nxt[rd_i] = 1'b0;
    end else begin
      w_pend_nxt[rd_i] = r_pend[rd_i];
    end
    if (w_iss_en) begin
      w_pend_nxt[iss_rd_i] = 1'b1;
    end else begin
      w_pend_nxt[iss_rd_i] = w_pend_nxt[iss_rd_i];
    end
  end

  // Register storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[rd_i] <= datord_i;
    end else begin
      r_mem[rd_i] <= r_mem[rd_i];
    end
  end

  // Scoreboard state and its registered population count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= popcnt(w_pend_nxt);
    end
  end

  // Read port 1.
  always_comb begin
    w_dat1 = r_mem[rs1_i];
    w_pnd1 = r_pend[rs1_i];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_en && (rd_i == rs1_i)) begin
      w_dat1 = datord_i;
      w_pnd1 = 1'b0;
    end else begin
      w_dat1 = r_mem[rs1_i];
    end
`endif
    if (w_zero_en && (rs1_i == '0)) begin
      w_dat1 = '0;
      w_pnd1 = 1'b0;
    end else begin
      w_pnd1 = w_pnd1;
    end
  end

  // Read port 2.
  always_comb begin
    w_dat2 = r_mem[rs2_i];
    w_pnd2 = r_pend[rs2_i];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_en && (rd_i == rs2_i)) begin
      w_dat2 = datord_i;
      w_pnd2 = 1'b0;
    end else begin
      w_dat2 = r_mem[rs2_i];
    end
`endif
    if (w_zero_en && (rs2_i == '0)) begin
      w_dat2 = '0;
      w_pnd2 = 1'b0;
    end else begin
      w_pnd2 = w_pnd2;
    end
  end

  assign datos1_o   = w_dat1;
  assign datos2_o   = w_dat2;
  assign pend1_o    = w_pnd1;
  assign pend2_o    = w_pnd2;
  assign pend_cnt_o = r_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb (default parameters); expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rs1, rs2, rd, iss_rd;
  logic [DW-1:0] d1, d2, wd;
  logic          we, iss, p1, p2;
  logic [AW:0]   cnt;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] rd;
    logic [DW-1:0] wd;
    logic          iss;
    logic [AW-1:0] iss_rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [DW-1:0] e_d1;
    logic [DW-1:0] e_d2;
    logic          e_p1;
    logic          e_p2;
    logic [AW:0]   e_cnt;
  } vec_t;

  vec_t vecs[$];

  regfile_sb #(.DW(DW), .AW(AW), .ZERO_REG(1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rs1_i(rs1), .rs2_i(rs2), .datos1_o(d1), .datos2_o(d2),
    .rd_i(rd), .datord_i(wd), .we_i(we),
    .iss_i(iss), .iss_rd_i(iss_rd),
    .pend1_o(p1), .pend2_o(p2), .pend_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic a_we, input logic [AW-1:0] a_rd, input logic [DW-1:0] a_wd,
                     input logic a_iss, input logic [AW-1:0] a_ird,
                     input logic [AW-1:0] a_rs1, input logic [AW-1:0] a_rs2,
                     input logic [DW-1:0] a_d1, input logic [DW-1:0] a_d2,
                     input logic a_p1, input logic a_p2, input logic [AW:0] a_cnt);
    vec_t v;
    v = '{a_we, a_rd, a_wd, a_iss, a_ird, a_rs1, a_rs2, a_d1, a_d2, a_p1, a_p2, a_cnt};
    vecs.push_back(v);
  endtask

  task automatic idle();
    we = 1'b0; rd = '0; wd = '0; iss = 1'b0; iss_rd = '0;
  endtask

  initial begin
    rst_n = 1'b0; idle(); rs1 = '0; rs2 = '0;

    // Write/read latency, scoreboard, simultaneous issue+writeback, write to a non-pending register.
    add(1, 7, 32'h12345678, 0, 0, 7, 7, BYP ? 32'h12345678 : 32'h0, BYP ? 32'h12345678 : 32'h0, 0, 0, 0);
    add(0, 0, 0,            0, 0, 7, 7, 32'h12345678, 32'h12345678, 0, 0, 0);
    add(0, 0, 0,            1, 3, 3, 4, 0, 0, 0, 0, 0);
    add(0, 0, 0,            1, 4, 3, 4, 0, 0, 1, 0, 1);
    add(0, 0, 0,            1, 3, 3, 4, 0, 0, 1, 1, 2);
    add(0, 0, 0,            0, 0, 3, 4, 0, 0, 1, 1, 2);
    add(1, 3, 32'hAAAA0003, 0, 0, 3, 4, BYP ? 32'hAAAA0003 : 32'h0, 0, !BYP, 1, 2);
    add(1, 4, 32'hBBBB0004, 0, 0, 3, 4, 32'hAAAA0003, BYP ? 32'hBBBB0004 : 32'h0, 0, !BYP, 1);
    add(0, 0, 0,            0, 0, 3, 4, 32'hAAAA0003, 32'hBBBB0004, 0, 0, 0);
    add(0, 0, 0,            1, 9, 9, 7, 0, 32'h12345678, 0, 0, 0);
    add(1, 9, 32'h99999999, 1, 9, 9, 9, BYP ? 32'h99999999 : 32'h0, BYP ? 32'h99999999 : 32'h0, !BYP, !BYP, 1);
    add(0, 0, 0,            0, 0, 9, 9, 32'h99999999, 32'h99999999, 1, 1, 1);
    add(1, 10, 32'h0A0A0A0A, 0, 0, 9, 10, 32'h99999999, BYP ? 32'h0A0A0A0A : 32'h0, 1, 0, 1);
    add(0, 0, 0,            0, 0, 10, 9, 32'h0A0A0A0A, 32'h99999999, 0, 1, 1);
    add(1, 9, 32'h99999999, 0, 0, 9, 0, 32'h99999999, 0, !BYP, 0, 1);
    add(0, 0, 0,            0, 0, 9, 5, 32'h99999999, 0, 0, 0, 0);

    // Reset clears previously written data.
    step(); step();
    rst_n = 1'b1;
    step();
    we = 1'b1; rd = 5'd5; wd = 32'hDEADBEEF;
    step();
    idle(); rs1 = 5'd5; rs2 = 5'd5;
    #1;
    chk("pre_reset_r5", d1, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    chk("async_reset_r5", d2, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("reset_r5", d1, 32'h0);
    chk("reset_cnt", {26'h0, cnt}, 32'h0);
    chk("reset_pend", {30'h0, p1, p2}, 32'h0);

    // Register 0 is never written or marked pending.
    we = 1'b1; rd = 5'd0; wd = 32'hFFFFFFFF;
    step();
    idle(); iss = 1'b1; iss_rd = 5'd0;
    step();
    idle(); rs1 = 5'd0;
    #1;
    chk("zero_data", d1, 32'h0);
    chk("zero_pend", {31'h0, p1}, 32'h0);
    chk("zero_cnt", {26'h0, cnt}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      we = vecs[i].we; rd = vecs[i].rd; wd = vecs[i].wd;
      iss = vecs[i].iss; iss_rd = vecs[i].iss_rd;
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
      #1;
      chk($sformatf("v%0d_d1", i), d1, vecs[i].e_d1);
      chk($sformatf("v%0d_d2", i), d2, vecs[i].e_d2);
      chk($sformatf("v%0d_p1", i), {31'h0, p1}, {31'h0, vecs[i].e_p1});
      chk($sformatf("v%0d_p2", i), {31'h0, p2}, {31'h0, vecs[i].e_p2});
      chk($sformatf("v%0d_cnt", i), {26'h0, cnt}, {26'h0, vecs[i].e_cnt});
      step();
    end
    idle();

    // Fill every non-zero register, then reset asynchronously mid-cycle.
    for (int i = 1; i < 32; i++) begin
      iss = 1'b1; iss_rd = AW'(i);
      step();
    end
    idle(); rs1 = 5'd31; rs2 = 5'd0;
    #1;
    chk("fill_cnt", {26'h0, cnt}, 32'd31);
    chk("fill_p31", {31'h0, p1}, 32'h1);
    chk("fill_p0", {31'h0, p2}, 32'h0);
    #2;
    rst_n = 1'b0;
    iss = 1'b1; iss_rd = 5'd5; we = 1'b1; rd = 5'd3; wd = 32'h5A5A5A5A;
    #1;
    chk("mid_reset_cnt", {26'h0, cnt}, 32'h0);
    chk("mid_reset_p31", {31'h0, p1}, 32'h0);
    step();
    rs1 = 5'd5; rs2 = 5'd3;
    #1;
    chk("reset_ignores_iss", {26'h0, cnt}, 32'h0);
    chk("reset_ignores_we", d2, 32'h0);
    idle();
    rst_n = 1'b1;
    step();
    chk("post_reset_cnt", {26'h0, cnt}, 32'h0);
    chk("post_reset_p5", {31'h0, p1}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
